// File: rtl/apb_enum_pkg.sv
// Shared APB enumerations: protection attribute layout and the requester
// transfer state.
package apb_enum;

  // APB protection attribute, one bit per field (MSB..LSB).
  typedef struct packed {
    logic instruction;  // bit2: 0 = data, 1 = instruction
    logic nonsecure;    // bit1: 0 = secure, 1 = non-secure
    logic privileged;   // bit0: 0 = normal, 1 = privileged
  } apb_prot_t;

  // Requester transfer phases.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

endpackage

// File: rtl/apb_requester.sv
// APB requester: accepts one command, runs a single SETUP/ACCESS transfer
// and presents the completion on a valid/ready response channel.
// Optional feature: define APB_REQUESTER_TIMEOUT_EN to bound the ACCESS
// phase to TIMEOUT_CYCLES cycles (timeout reported as error + timeout flag).
module apb_requester
  import apb_enum::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
  input  logic [2:0]              cmd_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  output logic [2:0]              pprot_o,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pready_i,
  input  logic                    pslverr_i
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  // Reject unusable configurations at elaboration time.
  if ((DATA_WIDTH % 8 != 0) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("apb_requester: DATA_WIDTH must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
  end

  apb_state_t              state_r;
  apb_state_t              state_next_s;
  logic                    accept_s;
  logic                    access_done_s;
  logic                    timeout_hit_s;
  logic                    psel_next_s;
  logic                    penable_next_s;
  logic                    cmd_ready_next_s;
  logic                    rsp_valid_next_s;

  logic                    cmd_ready_r;
  logic                    rsp_valid_r;
  logic                    psel_r;
  logic                    penable_r;
  logic                    pwrite_r;
  logic [ADDR_WIDTH-1:0]   paddr_r;
  logic [DATA_WIDTH-1:0]   pwdata_r;
  logic [STRB_WIDTH-1:0]   pstrb_r;
  logic [2:0]              pprot_r;
  logic [DATA_WIDTH-1:0]   rsp_rdata_r;
  logic                    rsp_err_r;

  // The registered ready (not the state) gates acceptance, so nothing is
  // taken on the first edge after reset release while cmd_ready_o is still 0.
  assign accept_s = cmd_valid_i & cmd_ready_r;
  // pready_i/pslverr_i only matter in ACCESS, where psel and penable are both 1.
  assign access_done_s = (state_r == ACCESS) & pready_i;

`ifdef APB_REQUESTER_TIMEOUT_EN
  localparam int unsigned          CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] access_cnt_r;
  logic                 rsp_timeout_r;

  // A ready in the last allowed cycle takes priority over the timeout.
  assign timeout_hit_s = (state_r == ACCESS) & ~pready_i & (access_cnt_r == CNT_LAST);

  // Count ACCESS cycles of the current transfer; cleared when SETUP is entered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      access_cnt_r <= '0;
    end else if (accept_s) begin
      access_cnt_r <= '0;
    end else if (state_r == ACCESS) begin
      access_cnt_r <= access_cnt_r + CNT_WIDTH'(1);
    end
  end

  // Timeout flag of the response, updated when ACCESS ends.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_timeout_r <= 1'b0;
    end else if (access_done_s) begin
      rsp_timeout_r <= 1'b0;
    end else if (timeout_hit_s) begin
      rsp_timeout_r <= 1'b1;
    end
  end

  assign rsp_timeout_o = rsp_timeout_r;
`else
  assign timeout_hit_s = 1'b0;
  assign rsp_timeout_o = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = SETUP;
        end else begin
          state_next_s = IDLE;
        end
      end
      SETUP: begin
        state_next_s = ACCESS;
      end
      ACCESS: begin
        if (access_done_s) begin
          state_next_s = RESP;
        end else if (timeout_hit_s) begin
          state_next_s = RESP;
        end else begin
          state_next_s = ACCESS;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Control outputs for the upcoming state; registered below so they are glitch-free.
  always_comb begin
    psel_next_s      = 1'b0;
    penable_next_s   = 1'b0;
    cmd_ready_next_s = 1'b0;
    rsp_valid_next_s = 1'b0;
    case (state_next_s)
      IDLE:    cmd_ready_next_s = 1'b1;
      SETUP:   psel_next_s      = 1'b1;
      ACCESS: begin
        psel_next_s    = 1'b1;
        penable_next_s = 1'b1;
      end
      RESP:    rsp_valid_next_s = 1'b1;
      default: cmd_ready_next_s = 1'b0;
    endcase
  end

  // Control output registers; all zero while in reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
    end else begin
      cmd_ready_r <= cmd_ready_next_s;
      rsp_valid_r <= rsp_valid_next_s;
      psel_r      <= psel_next_s;
      penable_r   <= penable_next_s;
    end
  end

  // Capture the command payload on acceptance; it holds until the next command.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwrite_r <= 1'b0;
      paddr_r  <= '0;
      pwdata_r <= '0;
      pstrb_r  <= '0;
      pprot_r  <= 3'b000;
    end else if (accept_s) begin
      pwrite_r <= cmd_write_i;
      paddr_r  <= cmd_addr_i;
      pwdata_r <= cmd_write_i ? cmd_wdata_i : '0;
      pstrb_r  <= cmd_write_i ? cmd_wstrb_i : '0;
      pprot_r  <= cmd_prot_i;
    end
  end

  // Capture the completion: slave response on ready, or a synthetic error on timeout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
    end else if (access_done_s) begin
      rsp_rdata_r <= pwrite_r ? '0 : prdata_i;
      rsp_err_r   <= pslverr_i;
    end else if (timeout_hit_s) begin
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b1;
    end
  end

  assign cmd_ready_o = cmd_ready_r;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_rdata_o = rsp_rdata_r;
  assign rsp_err_o   = rsp_err_r;
  assign psel_o      = psel_r;
  assign penable_o   = penable_r;
  assign pwrite_o    = pwrite_r;
  assign paddr_o     = paddr_r;
  assign pwdata_o    = pwdata_r;
  assign pstrb_o     = pstrb_r;
  assign pprot_o     = pprot_r;

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: directed transfers plus randomized
// commands, each checked cycle by cycle against a transfer-level model.
module tb_apb_requester;

`ifdef APB_REQUESTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic [3:0]  cmd_wstrb_i;
  logic [2:0]  cmd_prot_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [2:0]  pprot_o;
  logic [31:0] prdata_i;
  logic        pready_i;
  logic        pslverr_i;

  int n_tests = 0;
  int n_fail  = 0;

  apb_requester #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_write_i  (cmd_write_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_wdata_i  (cmd_wdata_i),
    .cmd_wstrb_i  (cmd_wstrb_i),
    .cmd_prot_i   (cmd_prot_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .pwrite_o     (pwrite_o),
    .paddr_o      (paddr_o),
    .pwdata_o     (pwdata_o),
    .pstrb_o      (pstrb_o),
    .pprot_o      (pprot_o),
    .prdata_i     (prdata_i),
    .pready_i     (pready_i),
    .pslverr_i    (pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // APB payload expected to be held on the bus for the current transfer.
  task automatic check_bus(input string ph, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr);
    check_eq({ph, "_pwrite"}, pwrite_o, wr);
    check_eq({ph, "_paddr"},  paddr_o,  a);
    check_eq({ph, "_pwdata"}, pwdata_o, wd);
    check_eq({ph, "_pstrb"},  pstrb_o,  st);
    check_eq({ph, "_pprot"},  pprot_o,  pr);
  endtask

  // One complete command -> APB transfer -> response, starting at a negedge in IDLE.
  // wait_n: ACCESS cycles with pready low before ready; rsp_wait: cycles rsp_ready is held low.
  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot, input int wait_n,
                          input logic err, input logic [31:0] rdata, input int rsp_wait);
    logic        to_exp;
    int          n_acc;
    logic [31:0] e_wd, e_rd;
    logic [3:0]  e_st;
    logic        e_err;
    to_exp = TO_EN && (wait_n >= TO);
    n_acc  = to_exp ? TO : wait_n + 1;
    e_wd   = wr ? wdata : 32'd0;
    e_st   = wr ? strb : 4'd0;
    e_rd   = (to_exp || wr) ? 32'd0 : rdata;
    e_err  = to_exp ? 1'b1 : err;

    check_eq("idle_cmd_ready", cmd_ready_o, 1'b1);
    check_eq("idle_psel", psel_o, 1'b0);
    check_eq("idle_rsp_valid", rsp_valid_o, 1'b0);
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr;
    cmd_wdata_i = wdata; cmd_wstrb_i = strb; cmd_prot_i = prot;
    pready_i = 1'b1; pslverr_i = 1'b1;
    @(negedge clk_i);

    // SETUP cycle (N+1)
    check_eq("setup_psel", psel_o, 1'b1);
    check_eq("setup_penable", penable_o, 1'b0);
    check_eq("setup_cmd_ready", cmd_ready_o, 1'b0);
    check_eq("setup_rsp_valid", rsp_valid_o, 1'b0);
    check_bus("setup", wr, addr, e_wd, e_st, prot);
    cmd_valid_i = 1'b0; cmd_addr_i = $urandom; cmd_wdata_i = $urandom;
    pready_i = 1'b1; pslverr_i = 1'b1; prdata_i = $urandom;
    @(negedge clk_i);

    // ACCESS cycles (from N+2)
    for (int k = 0; k < n_acc; k++) begin
      check_eq("access_psel", psel_o, 1'b1);
      check_eq("access_penable", penable_o, 1'b1);
      check_eq("access_rsp_valid", rsp_valid_o, 1'b0);
      check_bus("access", wr, addr, e_wd, e_st, prot);
      pready_i  = (!to_exp && k == wait_n);
      pslverr_i = pready_i ? err : 1'($urandom);
      prdata_i  = pready_i ? rdata : $urandom;
      @(negedge clk_i);
    end

    // RESP: fields stable while rsp_ready is low; a competing command must not be taken.
    for (int j = 0; j <= rsp_wait; j++) begin
      check_eq("resp_valid", rsp_valid_o, 1'b1);
      check_eq("resp_rdata", rsp_rdata_o, e_rd);
      check_eq("resp_err", rsp_err_o, e_err);
      check_eq("resp_timeout", rsp_timeout_o, to_exp);
      check_eq("resp_psel", psel_o, 1'b0);
      check_eq("resp_penable", penable_o, 1'b0);
      check_eq("resp_cmd_ready", cmd_ready_o, 1'b0);
      check_bus("resp", wr, addr, e_wd, e_st, prot);
      cmd_valid_i = 1'b1; cmd_addr_i = $urandom; cmd_write_i = 1'($urandom);
      pready_i = 1'b1; pslverr_i = 1'($urandom); prdata_i = $urandom;
      rsp_ready_i = (j == rsp_wait);
      @(negedge clk_i);
    end
    check_eq("post_rsp_valid", rsp_valid_o, 1'b0);
    check_eq("post_psel", psel_o, 1'b0);
    rsp_ready_i = 1'b0;
    cmd_valid_i = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = 32'd0;
    cmd_wdata_i = 32'd0; cmd_wstrb_i = 4'd0; cmd_prot_i = 3'd0; rsp_ready_i = 1'b0;
    prdata_i = 32'd0; pready_i = 1'b0; pslverr_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    // Reset state: everything zero, including cmd_ready
    check_eq("rst_cmd_ready", cmd_ready_o, 1'b0);
    check_eq("rst_rsp_valid", rsp_valid_o, 1'b0);
    check_eq("rst_psel", psel_o, 1'b0);
    check_eq("rst_penable", penable_o, 1'b0);
    check_bus("rst", 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
    check_eq("rst_rdata", rsp_rdata_o, 32'd0);
    check_eq("rst_err", rsp_err_o, 1'b0);
    check_eq("rst_timeout", rsp_timeout_o, 1'b0);
    cmd_valid_i = 1'b1;  // must not be taken on the release edge
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("rel_cmd_ready", cmd_ready_o, 1'b1);
    check_eq("rel_psel", psel_o, 1'b0);
    cmd_valid_i = 1'b0;

    // Directed: immediate write, delayed read, slave error, long response stall
    run_xfer(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 3'b001, 0, 1'b0, 32'd0, 0);
    run_xfer(1'b0, 32'h0000_2004, 32'hAAAA_5555, 4'hF, 3'b010, 3, 1'b0, 32'h1234_5678, 0);
    run_xfer(1'b0, 32'h0000_3008, 32'd0, 4'h0, 3'b100, 1, 1'b1, 32'hCAFE_F00D, 5);
    // Timeout boundary: held low (timeout when enabled), then ready exactly on cycle 4
    run_xfer(1'b0, 32'h0000_400C, 32'd0, 4'h0, 3'b000, 10, 1'b0, 32'h0BAD_0BAD, 1);
    run_xfer(1'b1, 32'h0000_5010, 32'h0102_0304, 4'h5, 3'b111, TO - 1, 1'b0, 32'd0, 0);
    run_xfer(1'b0, 32'h0000_6014, 32'd0, 4'h0, 3'b011, 20, 1'b1, 32'h5555_AAAA, 2);

    // Reset during ACCESS aborts the transfer
    check_eq("abort_idle_ready", cmd_ready_o, 1'b1);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 32'h0000_7000;
    cmd_wdata_i = 32'h7777_7777; cmd_wstrb_i = 4'hF; cmd_prot_i = 3'b001; pready_i = 1'b0;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("abort_in_access", penable_o, 1'b1);
    rst_i = 1'b1; pready_i = 1'b1;
    @(negedge clk_i);
    check_eq("abort_psel", psel_o, 1'b0);
    check_eq("abort_penable", penable_o, 1'b0);
    check_eq("abort_rsp_valid", rsp_valid_o, 1'b0);
    check_eq("abort_cmd_ready", cmd_ready_o, 1'b0);
    check_eq("abort_paddr", paddr_o, 32'd0);
    rst_i = 1'b0; pready_i = 1'b0;
    @(negedge clk_i);
    check_eq("abort_rel_ready", cmd_ready_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_eq("abort_no_rsp", rsp_valid_o, 1'b0);
      check_eq("abort_no_psel", psel_o, 1'b0);
      @(negedge clk_i);
    end

    // Randomized transfers
    for (int t = 0; t < 40; t++) begin
      run_xfer(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
               $urandom_range(0, 6), 1'($urandom), $urandom, $urandom_range(0, 5));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
